// File: rtl/pulse_capture.sv
// pulse_capture: measures arm-to-rise delay, pulse width, gap and pulse count of one pulse train
// Optional macro PULSE_CAPTURE_SYNC_EN: sample pulse_in through a 2-flop synchronizer.
module pulse_capture #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm_in,
    input  logic             pulse_in,
    input  logic [15:0]      expected_count,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic             arm_ack,
    output logic             busy,
    output logic             done,
    output logic             done_strobe,
    output logic             timeout,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_gap,
    output logic [15:0]      pulse_count
);
    typedef enum logic [2:0] {IDLE, WAIT_RISE, HIGH, LOW, DONE} state_t;

    state_t           state;
    logic             p_s;
    logic             p_prev;
    logic             rise;
    logic             fall;
    logic             tmo_hit;
    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] ph_inc;
    logic [15:0]      cnt_inc;

`ifdef PULSE_CAPTURE_SYNC_EN
    logic [1:0] sync;

    // two-flop synchronizer for an asynchronous pulse source
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], pulse_in};

    assign p_s = sync[1];
`else
    assign p_s = pulse_in;
`endif

    assign rise    = p_s & ~p_prev;
    assign fall    = ~p_s & p_prev;
    assign ph_inc  = &ph ? ph : ph + CNT_W'(1);
    assign cnt_inc = &pulse_count ? pulse_count : pulse_count + 16'd1;
    assign tmo_hit = (timeout_cycles != '0) && (ph == timeout_cycles - CNT_W'(1));

    // capture FSM; width and gap include the edge cycle that opened the phase, hence ph_inc
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            p_prev      <= 1'b0;
            ph          <= '0;
            arm_ack     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_strobe <= 1'b0;
            timeout     <= 1'b0;
            meas_delay  <= '0;
            meas_width  <= '0;
            meas_gap    <= '0;
            pulse_count <= '0;
        end else begin
            p_prev      <= p_s;
            arm_ack     <= arm_in;
            done_strobe <= 1'b0;
            if (arm_in) begin
                state       <= WAIT_RISE;
                ph          <= '0;
                busy        <= 1'b1;
                done        <= 1'b0;
                timeout     <= 1'b0;
                meas_delay  <= '0;
                meas_width  <= '0;
                meas_gap    <= '0;
                pulse_count <= '0;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            meas_delay <= ph;
                            ph         <= '0;
                            state      <= HIGH;
                        end else if (tmo_hit) begin
                            meas_delay  <= timeout_cycles;
                            ph          <= '0;
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            done_strobe <= 1'b1;
                            timeout     <= 1'b1;
                        end else begin
                            ph <= ph_inc;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            meas_width  <= ph_inc;
                            pulse_count <= cnt_inc;
                            ph          <= '0;
                            if (expected_count != '0 && cnt_inc == expected_count) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                done_strobe <= 1'b1;
                            end else begin
                                state <= LOW;
                            end
                        end else if (tmo_hit) begin
                            meas_width  <= timeout_cycles;
                            ph          <= '0;
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            done_strobe <= 1'b1;
                            timeout     <= 1'b1;
                        end else begin
                            ph <= ph_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            meas_gap <= ph_inc;
                            ph       <= '0;
                            state    <= HIGH;
                        end else if (tmo_hit) begin
                            meas_gap    <= timeout_cycles;
                            ph          <= '0;
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            done_strobe <= 1'b1;
                            timeout     <= 1'b1;
                        end else begin
                            ph <= ph_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: scoreboard bench for pulse_capture, expected results queued per capture
module tb_pulse_capture;
`ifdef PULSE_CAPTURE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    typedef struct {
        int dly;
        int wid;
        int gap;
        int cnt;
        int tmo;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm_in = 1'b0;
    logic        pulse_in = 1'b0;
    logic [15:0] expected_count = '0;
    logic [31:0] timeout_cycles = '0;
    logic        arm_ack, busy, done, done_strobe, timeout;
    logic [31:0] meas_delay, meas_width, meas_gap;
    logic [15:0] pulse_count;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   arm_cyc = 0;
    exp_t sb[$];

    pulse_capture #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .arm_in(arm_in), .pulse_in(pulse_in),
        .expected_count(expected_count), .timeout_cycles(timeout_cycles),
        .arm_ack(arm_ack), .busy(busy), .done(done), .done_strobe(done_strobe),
        .timeout(timeout), .meas_delay(meas_delay), .meas_width(meas_width),
        .meas_gap(meas_gap), .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t count_exp(input int pre, input int d, input int w, input int g, input int n);
        exp_t e;
        e.dly = pre + d + SD;
        e.wid = w;
        e.gap = n > 1 ? g : 0;
        e.cnt = n;
        e.tmo = 0;
        e.lat = pre + d + 2 + (n - 1) * (w + g) + w + SD;
        return e;
    endfunction

    // scoreboard: every done_strobe must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done_strobe) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("delay", meas_delay, e.dly);
                check("width", meas_width, e.wid);
                check("gap", meas_gap, e.gap);
                check("count", pulse_count, e.cnt);
                check("timeout", timeout, e.tmo);
                check("done_lat", cyc - arm_cyc, e.lat);
            end
        end
    end

    // arm with the first wave sample; then pre high, d low, n pulses (w high, g low between), tail low
    task automatic play(input bit arm_lvl, input int pre, input int d, input int w, input int g,
                        input int n, input int tail, input logic [15:0] ec, input logic [31:0] tc,
                        input bit fin);
        logic wave[$];
        wave.push_back(arm_lvl);
        repeat (pre) wave.push_back(1'b1);
        repeat (d) wave.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (w) wave.push_back(1'b1);
            if (i < n - 1) repeat (g) wave.push_back(1'b0);
        end
        repeat (tail) wave.push_back(1'b0);
        expected_count = ec;
        timeout_cycles = tc;
        foreach (wave[i]) begin
            @(posedge clk);
            #1;
            arm_in = (i == 0);
            if (i == 0) arm_cyc = cyc;
            pulse_in = wave[i];
            if (i == 1) begin
                @(negedge clk);
                check("arm_ack", arm_ack, 1);
                check("arm_busy", busy, 1);
                check("arm_clear", {done, timeout, meas_delay, meas_width, pulse_count}, 0);
            end
            if (i == 2) begin
                @(negedge clk);
                check("arm_ack_1cyc", arm_ack, 0);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("end_state", {done, done_strobe, busy}, fin ? 3'b100 : 3'b001);
        check("pending", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        #2;
        check("rst_flags", {arm_ack, busy, done, done_strobe, timeout}, 0);
        check("rst_meas", {meas_delay, meas_width, meas_gap, pulse_count}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // free running: results update live, no done
        play(0, 0, 2, 4, 3, 3, 5, 16'd0, 32'd0, 1'b0);
        check("free_delay", meas_delay, 2 + SD);
        check("free_width", meas_width, 4);
        check("free_gap", meas_gap, 3);
        check("free_count", pulse_count, 3);

        // asynchronous reset mid-capture clears everything immediately
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_flags", {arm_ack, busy, done, done_strobe, timeout}, 0);
        check("midrst_meas", {meas_delay, meas_width, meas_gap, pulse_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 pulse_in = ~pulse_in;
        end
        @(posedge clk);
        #1 pulse_in = 1'b0;
        @(negedge clk);
        check("idle_flags", {arm_ack, busy, done, done_strobe, timeout}, 0);
        check("idle_meas", {meas_delay, meas_width, meas_gap, pulse_count}, 0);

        // loopback-style train: delay 5, width 3, gap 5, four pulses
        sb.push_back(count_exp(0, 5, 3, 5, 4));
        play(0, 0, 5, 3, 5, 4, 6, 16'd4, 32'd0, 1'b1);

        // single-cycle pulses and gaps with a timeout that never fires
        sb.push_back(count_exp(0, 2, 1, 1, 3));
        play(0, 0, 2, 1, 1, 3, 6, 16'd3, 32'd50, 1'b1);

        // timeout while waiting for the first rise
        e = '{dly: 20, wid: 0, gap: 0, cnt: 0, tmo: 1, lat: 21};
        sb.push_back(e);
        play(0, 0, 30, 0, 0, 0, 0, 16'd0, 32'd20, 1'b1);

        // timeout while high: width takes the timeout value, count stays 0
        e = '{dly: 3 + SD, wid: 8, gap: 0, cnt: 0, tmo: 1, lat: 13 + SD};
        sb.push_back(e);
        play(0, 0, 3, 20, 0, 1, 4, 16'd0, 32'd8, 1'b1);

        // input high at arm (rise coincident with arm ignored), high cycles count into delay
        sb.push_back(count_exp(3, 4, 6, 0, 1));
        play(1, 3, 4, 6, 0, 1, 6, 16'd1, 32'd0, 1'b1);

        // re-arm while HIGH: results cleared, capture restarts from WAIT_RISE
        expected_count = 16'd0;
        timeout_cycles = 32'd0;
        @(posedge clk);
        #1;
        arm_in = 1'b1;
        arm_cyc = cyc;
        pulse_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            arm_in = 1'b0;
            pulse_in = (i >= 4);
        end
        @(negedge clk);
        check("pre_rearm_delay", meas_delay, 3 + SD);
        check("pre_rearm_busy", busy, 1);
        sb.push_back(count_exp(2, 4, 5, 0, 1));
        play(1, 2, 4, 5, 0, 1, 6, 16'd1, 32'd0, 1'b1);

        // longer external pulse: 10 low, 7 high
        sb.push_back(count_exp(0, 10, 7, 0, 1));
        play(0, 0, 10, 7, 0, 1, 6, 16'd1, 32'd0, 1'b1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
